// File: rtl/level_pkg.sv
// Shared tile codes, level state encoding and the elaboration-time coin counter.
package level_pkg;

  localparam int TILE_BDR = 0;
  localparam int TILE_SKY = 1;
  localparam int TILE_BLK = 2;
  localparam int TILE_GND = 3;
  localparam int TILE_TKN = 4;
  localparam int TILE_CK1 = 5;
  localparam int TILE_CK2 = 6;

  // Largest map the coin counter can walk; maps are zero-extended into this width.
  localparam int MAX_CELLS = 1024;

  typedef logic [MAX_CELLS*8-1:0] flat_map_t;

  typedef enum logic [1:0] {PLAY, WON, LOST} level_state_e;

  function automatic int count_tkn(input flat_map_t flat, input int cells, input int tkn);
    int n;
    n = 0;
    for (int i = 0; i < cells && i < MAX_CELLS; i++) begin
      if (flat[i*8 +: 8] == 8'(tkn)) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/level_engine_if.sv
// Player inputs into the level engine and the live map/score it reports back.
interface level_engine_if #(
  parameter int ROWS = 12,
  parameter int COLS = 17
);
  int                             mario_x;
  int                             mario_y;
  logic                           enemy_hit;
  logic [ROWS-1:0][COLS-1:0][7:0] background;
  int                             coins_left;
  int                             seconds_left;
  logic                           win;
  logic                           lose;
  logic [9:0]                     leds;

  modport master (
    output mario_x, mario_y, enemy_hit,
    input  background, coins_left, seconds_left, win, lose, leds
  );

  modport slave (
    input  mario_x, mario_y, enemy_hit,
    output background, coins_left, seconds_left, win, lose, leds
  );
endinterface

// File: rtl/tile_overlap.sv
// Strict box overlap between Mario and one map tile; purely combinational.
module tile_overlap #(
  parameter int ROWS            = 12,
  parameter int COLS            = 17,
  parameter int CHARACTER_WIDTH = 42,
  parameter int BLOCK_WIDTH     = 40
) (
  input  int   mario_x,
  input  int   mario_y,
  input  int   tile_y,
  input  int   tile_x,
  output logic hit
);
  int left;
  int top;

  // x runs right-to-left and y bottom-to-top, so tile (0,0) sits bottom-right.
  always_comb begin
    left = (COLS - 1 - tile_x) * BLOCK_WIDTH;
    top  = (ROWS - 1 - tile_y) * BLOCK_WIDTH;
    hit  = (mario_x < left + BLOCK_WIDTH) && (mario_x + CHARACTER_WIDTH > left) &&
           (mario_y < top + BLOCK_WIDTH)  && (mario_y + CHARACTER_WIDTH > top);
  end
endmodule

// File: rtl/level_engine.sv
// Level FSM: scans one tile per cycle, turns coins under Mario into sky, counts down the clock.
// Collect latency at most ROWS*COLS cycles; no backpressure, WON/LOST freeze everything until reset.
module level_engine
  import level_pkg::*;
#(
  parameter int ROWS            = 12,
  parameter int COLS            = 17,
  parameter int BDR             = TILE_BDR,
  parameter int SKY             = TILE_SKY,
  parameter int BLK             = TILE_BLK,
  parameter int GND             = TILE_GND,
  parameter int TKN             = TILE_TKN,
  parameter int CK1             = TILE_CK1,
  parameter int CK2             = TILE_CK2,
  parameter int CHARACTER_WIDTH = 42,
  parameter int BLOCK_WIDTH     = 40,
  parameter int SCREEN_WIDTH    = 640,
  parameter int SCREEN_HEIGHT   = 480,
  parameter logic [ROWS-1:0][COLS-1:0][7:0] INIT_MAP = {(ROWS*COLS){8'(SKY)}},
  parameter int CLK_HZ          = 25_000_000,
  parameter int TIME_LIMIT      = 60
) (
  input logic           vga_clock,
  input logic           reset,
  level_engine_if.slave lv
);
  localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int XW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int COIN_INIT = count_tkn(flat_map_t'(INIT_MAP), ROWS*COLS, TKN);
  // Coins are only collectable when the coin code is unique and the map covers the screen.
  localparam bit MAP_OK = (TKN != SKY) && (TKN != BDR) && (TKN != BLK) && (TKN != GND) &&
                          (TKN != CK1) && (TKN != CK2) &&
                          (COLS * BLOCK_WIDTH >= SCREEN_WIDTH) && (ROWS * BLOCK_WIDTH >= SCREEN_HEIGHT);

  level_state_e                   state;
  logic [ROWS-1:0][COLS-1:0][7:0] background_q;
  int                             coins_left;
  int                             seconds_left;
  int                             prescaler;
  logic [YW-1:0]                  sy;
  logic [XW-1:0]                  sx;
  logic                           win_q;
  logic                           lose_q;
  logic                           hit;
  logic                           collect;
  logic                           tick;

  tile_overlap #(
    .ROWS            (ROWS),
    .COLS            (COLS),
    .CHARACTER_WIDTH (CHARACTER_WIDTH),
    .BLOCK_WIDTH     (BLOCK_WIDTH)
  ) u_overlap (
    .mario_x (lv.mario_x),
    .mario_y (lv.mario_y),
    .tile_y  (int'(sy)),
    .tile_x  (int'(sx)),
    .hit     (hit)
  );

  assign collect = MAP_OK && (background_q[sy][sx] == 8'(TKN)) && hit;
  assign tick    = (prescaler == CLK_HZ - 1);

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      state        <= PLAY;
      background_q <= INIT_MAP;
      coins_left   <= COIN_INIT;
      seconds_left <= TIME_LIMIT;
      prescaler    <= 0;
      sy           <= '0;
      sx           <= '0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
    end else begin
      prescaler <= tick ? 0 : prescaler + 1;
      if (state == PLAY) begin
        // Win is checked first so a last coin and a timeout in the same cycle still win.
        if (coins_left == 0) begin
          state <= WON;
          win_q <= 1'b1;
        end else if (seconds_left == 0 || lv.enemy_hit) begin
          state  <= LOST;
          lose_q <= 1'b1;
        end
        if (collect) begin
          background_q[sy][sx] <= 8'(SKY);
          coins_left           <= coins_left - 1;
        end
        if (tick && seconds_left > 0) seconds_left <= seconds_left - 1;
        if (sx == XW'(COLS - 1)) begin
          sx <= '0;
          sy <= (sy == YW'(ROWS - 1)) ? '0 : sy + 1'b1;
        end else begin
          sx <= sx + 1'b1;
        end
      end
    end
  end

  assign lv.background   = background_q;
  assign lv.coins_left   = coins_left;
  assign lv.seconds_left = seconds_left;
  assign lv.win          = win_q;
  assign lv.lose         = lose_q;
  assign lv.leds         = coins_left[9:0];
endmodule

// File: tb/tb_level_engine.sv
// Self-checking bench for level_engine: overlap vector table plus timing/corner sequences.
module tb_level_engine;
  typedef logic [11:0][16:0][7:0] map_t;

  typedef struct {
    string      name;
    int         mx;
    int         my;
    logic [7:0] t66;
    logic [7:0] t214;
    int         coins;
  } vec_t;

  function automatic map_t mk_map(input int y0, input int x0, input int y1, input int x1);
    map_t m;
    m = {204{8'd1}};
    m[5][5] = 8'd3;
    if (y0 >= 0) m[y0[3:0]][x0[4:0]] = 8'd4;
    if (y1 >= 0) m[y1[3:0]][x1[4:0]] = 8'd4;
    return m;
  endfunction

  localparam map_t MAP_A = mk_map(6, 6, 2, 14);
  localparam map_t MAP_B = mk_map(8, 8, -1, 0);
  localparam map_t MAP_C = mk_map(0, 11, -1, 0);
  localparam map_t MAP_E = mk_map(3, 3, 3, 4);

  logic clk = 1'b0;
  logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0, rst_d = 1'b0, rst_e = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  vec_t vecs[10];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  level_engine_if #(.ROWS(12), .COLS(17)) ia ();
  level_engine_if #(.ROWS(12), .COLS(17)) ib ();
  level_engine_if #(.ROWS(12), .COLS(17)) ic ();
  level_engine_if #(.ROWS(12), .COLS(17)) id ();
  level_engine_if #(.ROWS(12), .COLS(17)) ie ();

  level_engine #(.INIT_MAP(MAP_A)) dut_a (.vga_clock(clk), .reset(rst_a), .lv(ia));
  level_engine #(.INIT_MAP(MAP_B), .CLK_HZ(4), .TIME_LIMIT(3)) dut_b (.vga_clock(clk), .reset(rst_b), .lv(ib));
  level_engine #(.INIT_MAP(MAP_C), .CLK_HZ(4), .TIME_LIMIT(3)) dut_c (.vga_clock(clk), .reset(rst_c), .lv(ic));
  level_engine dut_d (.vga_clock(clk), .reset(rst_d), .lv(id));
  level_engine #(.INIT_MAP(MAP_E)) dut_e (.vga_clock(clk), .reset(rst_e), .lv(ie));

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    int   cnt;
    int   exp_s;
    vec_t e;

    vecs[0] = '{"park_on_66",    400,   200, 8'd1, 8'd4, 1};
    vecs[1] = '{"touch_left",    358,   200, 8'd4, 8'd4, 2};
    vecs[2] = '{"overlap_left1", 359,   200, 8'd1, 8'd4, 1};
    vecs[3] = '{"touch_right",   440,   200, 8'd4, 8'd4, 2};
    vecs[4] = '{"overlap_right", 439,   200, 8'd1, 8'd4, 1};
    vecs[5] = '{"touch_top",     400,   158, 8'd4, 8'd4, 2};
    vecs[6] = '{"overlap_below", 400,   239, 8'd1, 8'd4, 1};
    vecs[7] = '{"touch_below",   400,   240, 8'd4, 8'd4, 2};
    vecs[8] = '{"offscreen_neg", -1000, -1000, 8'd4, 8'd4, 2};
    vecs[9] = '{"park_on_214",   80,    360, 8'd4, 8'd1, 1};

    ia.enemy_hit = 1'b0; ib.enemy_hit = 1'b0; ic.enemy_hit = 1'b0; id.enemy_hit = 1'b0; ie.enemy_hit = 1'b0;
    ia.mario_x = -1000; ia.mario_y = -1000;
    ib.mario_x = -1000; ib.mario_y = -1000;
    ic.mario_x = 200;   ic.mario_y = 440;
    id.mario_x = -1000; id.mario_y = -1000;
    ie.mario_x = 490;   ie.mario_y = 320;
    cyc(2);

    // Reset state of the two-coin map.
    chk("a_reset_coins", ia.coins_left, 2);
    chk("a_reset_seconds", ia.seconds_left, 60);
    chk("a_reset_win", ia.win, 0);
    chk("a_reset_lose", ia.lose, 0);
    chk("a_reset_tile66", ia.background[6][6], 4);
    chk("a_reset_leds", ia.leds, 2);

    // Overlap table: each record starts from reset and runs one full scan plus margin.
    for (int i = 0; i < 10; i++) begin
      rst_a = 1'b0;
      cyc(1);
      ia.mario_x = vecs[i].mx;
      ia.mario_y = vecs[i].my;
      exp_q.push_back(vecs[i]);
      rst_a = 1'b1;
      cyc(210);
      e = exp_q.pop_front();
      chk({e.name, "_t66"}, ia.background[6][6], e.t66);
      chk({e.name, "_t214"}, ia.background[2][14], e.t214);
      chk({e.name, "_coins"}, ia.coins_left, e.coins);
      chk({e.name, "_gnd55"}, ia.background[5][5], 3);
      chk({e.name, "_win"}, ia.win, 0);
    end

    // Collect within one scan, then enemy hit freezes the map, then reset restores it.
    rst_a = 1'b0;
    cyc(1);
    ia.mario_x = 400;
    ia.mario_y = 200;
    rst_a = 1'b1;
    cnt = 0;
    while (ia.coins_left == 2 && cnt < 204) begin
      cyc(1);
      cnt++;
    end
    chk("collect_coins", ia.coins_left, 1);
    chk("collect_tile66", ia.background[6][6], 1);
    chk("collect_win", ia.win, 0);
    chk("collect_leds", ia.leds, 1);
    ia.enemy_hit = 1'b1;
    cyc(1);
    ia.enemy_hit = 1'b0;
    cyc(1);
    chk("enemy_lose", ia.lose, 1);
    chk("enemy_win", ia.win, 0);
    ia.mario_x = 80;
    ia.mario_y = 360;
    cyc(210);
    chk("lost_frozen_t214", ia.background[2][14], 4);
    chk("lost_frozen_coins", ia.coins_left, 1);
    rst_a = 1'b0;
    #2;
    chk("midlost_reset_t66", ia.background[6][6], 4);
    chk("midlost_reset_coins", ia.coins_left, 2);
    chk("midlost_reset_seconds", ia.seconds_left, 60);
    chk("midlost_reset_lose", ia.lose, 0);
    cyc(1);
    rst_a = 1'b1;

    // Timeout countdown: CLK_HZ=4, TIME_LIMIT=3.
    rst_b = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      cyc(1);
      exp_s = (k < 4) ? 3 : (k < 8) ? 2 : (k < 12) ? 1 : 0;
      chk($sformatf("timeout_seconds_e%0d", k), ib.seconds_left, exp_s);
      chk($sformatf("timeout_lose_e%0d", k), ib.lose, (k >= 13) ? 1 : 0);
    end
    ib.mario_x = 320;
    ib.mario_y = 120;
    cyc(210);
    chk("timeout_frozen_t88", ib.background[8][8], 4);
    chk("timeout_frozen_coins", ib.coins_left, 1);
    chk("timeout_frozen_seconds", ib.seconds_left, 0);
    chk("timeout_win", ib.win, 0);

    // Last coin collected on the same edge the clock runs out.
    rst_c = 1'b1;
    cyc(12);
    chk("race_coins", ic.coins_left, 0);
    chk("race_seconds", ic.seconds_left, 0);
    chk("race_win_pre", ic.win, 0);
    cyc(1);
    chk("race_win", ic.win, 1);
    chk("race_lose", ic.lose, 0);

    // Coin-free map wins on the first edge after reset.
    chk("nocoin_reset_coins", id.coins_left, 0);
    chk("nocoin_reset_win", id.win, 0);
    rst_d = 1'b1;
    cyc(1);
    chk("nocoin_win", id.win, 1);
    chk("nocoin_lose", id.lose, 0);

    // Two adjacent coins under Mario at once.
    rst_e = 1'b1;
    cyc(55);
    chk("adj_first_coins", ie.coins_left, 1);
    chk("adj_first_t33", ie.background[3][3], 1);
    chk("adj_first_t34", ie.background[3][4], 4);
    cyc(1);
    chk("adj_second_coins", ie.coins_left, 0);
    chk("adj_second_t34", ie.background[3][4], 1);
    chk("adj_second_win", ie.win, 0);
    cyc(1);
    chk("adj_win", ie.win, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
